mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, sitting beside the ALU in the EX stage of the pipelined CPU. Accepts one operation per `start` pulse, holds `busy` for a configurable latency, then commits the result to HI/LO. The pipeline stalls any HI/LO-touching instruction in D/E while `start | busy` is high. Widths and latencies are parameters, so the same block serves 32-bit and narrower test builds.

## Interface
- `WIDTH`, 32: operand and HI/LO width.
- `MUL_CYCLES`, 5: busy cycles for MULT/MULTU/MADD/MADDU (≥1).
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU (≥1).
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: launch request, sampled on the rising edge.
- `md_op` in 3: 000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 MADD (signed).
- `src_a` in WIDTH: rs operand.
- `src_b` in WIDTH: rt operand.
- `busy` out 1: operation in flight; registered.
- `hi` out WIDTH: HI register; registered.
- `lo` out WIDTH: LO register; registered.

## Operation
- States: IDLE, RUN.
- IDLE, `start`=1, op ∈ {MULT, MULTU, MADD, DIV, DIVU}:
  - latch operands and op;
  - compute the result into internal staging;
  - load the counter with MUL_CYCLES or DIV_CYCLES;
  - go to RUN with `busy`=1.
- IDLE, `start`=1, MTHI/MTLO: write `src_a` to HI/LO at that edge. No busy, stays IDLE.
- IDLE, `start`=1, NOP: no effect.
- RUN: the counter decrements each edge. On the edge where it reaches 0:
  - commit staging to HI/LO;
  - set `busy`=0;
  - return to IDLE.
- `start` during RUN is ignored entirely, including MTHI/MTLO. The pipeline guarantees it is not asserted; the bench checks that it is ignored.
- Multiply:
  - MULT: {HI,LO} = signed(a)×signed(b), full 2·WIDTH product.
  - MULTU: the same, unsigned.
  - MADD: {HI,LO} = {HI,LO} + signed(a)×signed(b), mod 2^(2·WIDTH). The {HI,LO} value used is the one sampled at `start`.
- Divide:
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned LO = a/b, HI = a%b.
  - Signed overflow (a = −2^(WIDTH−1), b = −1): LO = −2^(WIDTH−1), HI = 0.
  - Divide by zero (b = 0): the op still occupies DIV_CYCLES with `busy` high, and HI/LO are left unchanged at commit.
- Counter width is $clog2(max(MUL_CYCLES, DIV_CYCLES)+1).

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0, state IDLE, counter 0.
- Asserting `reset` mid-RUN aborts the operation immediately. Staging is discarded and HI/LO are cleared to 0.
- Accept edge k: `busy` reads 1 after edge k.
- Multiply: `busy` falls and HI/LO update together after edge k+MUL_CYCLES.
- Divide: the same, after edge k+DIV_CYCLES.
- HI/LO hold their old values throughout RUN. A read during RUN returns the pre-operation value.
- MTHI/MTLO: the new value is visible after the accept edge. Latency 1, throughput 1 per cycle.
- Back-to-back: a new `start` is accepted on the first edge where `busy` is 0. Minimum spacing between multi-cycle ops is N+1 cycles.
- Outputs are purely registered, with no combinational path from inputs.

## Test plan
- Reset, then MULT a=0xFFFFFFFD (−3), b=5 → `busy` high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIVU a=100, b=7 → after 10 busy cycles LO=0x0000000E, HI=0x00000002. DIV a=−7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0, then DIV with b=0 → `busy` high 10 cycles; HI/LO still 0x12345678/0x9ABCDEF0.
- MTHI 0, MTLO 0xFFFFFFFF, then MADD a=1, b=1 → HI=0x00000001, LO=0x00000000.
- MULTU 0xFFFFFFFF×0xFFFFFFFF; pulse `start` with MTLO 0xAAAA during cycle 2 of busy → ignored; HI=0xFFFFFFFE, LO=0x00000001.
- DIVU started, `reset` pulsed at busy cycle 4 → `busy`=0, HI=LO=0 immediately. The next MULT 2×3 gives LO=6 after 5 cycles.
- Rebuild with WIDTH=16, MUL_CYCLES=1, DIV_CYCLES=3 → MULT 0x8000×0x8000 gives HI=0x4000, LO=0x0000 with a 1-cycle busy.

Source files
------------

// File: rtl/mul_div_unit_if.sv
// Purpose: request/result bundle between the EX stage and the multiply/divide unit.
// Latency: n/a (wiring only); signals: start/md_op/src_a/src_b toward the unit, busy/hi/lo back.
// Backpressure: the requester must hold off start while busy is high; the unit drops it otherwise.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       md_op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, md_op, src_a, src_b,
        input  busy, hi, lo
    );

    modport slave (
        input  start, md_op, src_a, src_b,
        output busy, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Purpose: multi-cycle MULT/MULTU/MADD/DIV/DIVU unit owning the architectural HI/LO registers.
// Latency: MUL_CYCLES / DIV_CYCLES edges from accept to HI/LO commit; MTHI/MTLO take effect at the accept edge.
// Backpressure: busy is high while an op is in flight; any start seen during that time is dropped.
// Ports: clk, reset (async, active-high), md (slave side of mul_div_unit_if: start, md_op, src_a, src_b in;
//        busy, hi, lo out, all registered).
module mul_div_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic          clk,
    input  logic          reset,
    mul_div_unit_if.slave md
);
    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int W2         = 2 * WIDTH;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    localparam logic [2:0] OP_MADD  = 3'b111;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] stg_hi_q, stg_hi_d;
    logic [WIDTH-1:0] stg_lo_q, stg_lo_d;
    logic             stg_wr_q, stg_wr_d;   // clear for divide-by-zero: commit leaves HI/LO alone

    // Multiply datapath. Sign-extending to 2*WIDTH and keeping the low 2*WIDTH
    // bits of the product yields the exact signed product without signed types.
    logic [W2-1:0] a_sx, b_sx, a_zx, b_zx;
    logic [W2-1:0] prod_s, prod_u, madd_sum;

    always_comb begin
        a_sx     = {{WIDTH{md.src_a[WIDTH-1]}}, md.src_a};
        b_sx     = {{WIDTH{md.src_b[WIDTH-1]}}, md.src_b};
        a_zx     = {{WIDTH{1'b0}}, md.src_a};
        b_zx     = {{WIDTH{1'b0}}, md.src_b};
        prod_s   = a_sx * b_sx;
        prod_u   = a_zx * b_zx;
        madd_sum = {hi_q, lo_q} + prod_s;
    end

    // Divide datapath. Signed divide works on magnitudes; the quotient is negated
    // when operand signs differ and the remainder follows the dividend. The
    // overflow case (-2^(W-1) / -1) falls out naturally: magnitude 2^(W-1)
    // negates back to itself and the remainder is 0.
    logic [WIDTH-1:0] div_b, abs_a, abs_b;
    logic [WIDTH-1:0] uq, ur, mq, mr, sq, sr;
    logic             b_zero;

    always_comb begin
        b_zero = (md.src_b == '0);
        div_b  = b_zero ? ONE : md.src_b;    // keeps the divider defined; result is discarded anyway
        abs_a  = md.src_a[WIDTH-1] ? (-md.src_a) : md.src_a;
        abs_b  = div_b[WIDTH-1] ? (-div_b) : div_b;
        uq     = md.src_a / div_b;
        ur     = md.src_a % div_b;
        mq     = abs_a / abs_b;
        mr     = abs_a % abs_b;
        sq     = (md.src_a[WIDTH-1] ^ div_b[WIDTH-1]) ? (-mq) : mq;
        sr     = md.src_a[WIDTH-1] ? (-mr) : mr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            stg_hi_q <= '0;
            stg_lo_q <= '0;
            stg_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            stg_hi_q <= stg_hi_d;
            stg_lo_q <= stg_lo_d;
            stg_wr_q <= stg_wr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        stg_hi_d = stg_hi_q;
        stg_lo_d = stg_lo_q;
        stg_wr_d = stg_wr_q;

        case (state_q)
            IDLE: begin
                if (md.start) begin
                    case (md.md_op)
                        OP_MULT, OP_MULTU, OP_MADD: begin
                            {stg_hi_d, stg_lo_d} = (md.md_op == OP_MULT)  ? prod_s :
                                                   (md.md_op == OP_MULTU) ? prod_u : madd_sum;
                            stg_wr_d = 1'b1;
                            cnt_d    = CNT_W'(MUL_CYCLES);
                            busy_d   = 1'b1;
                            state_d  = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            stg_lo_d = (md.md_op == OP_DIV) ? sq : uq;
                            stg_hi_d = (md.md_op == OP_DIV) ? sr : ur;
                            stg_wr_d = !b_zero;
                            cnt_d    = CNT_W'(DIV_CYCLES);
                            busy_d   = 1'b1;
                            state_d  = RUN;
                        end
                        OP_MTHI: hi_d = md.src_a;
                        OP_MTLO: lo_d = md.src_a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // start is deliberately not looked at here.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                    if (stg_wr_q) begin
                        hi_d = stg_hi_q;
                        lo_d = stg_lo_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign md.busy = busy_q;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
    localparam logic [2:0] NOP = 3'd0, MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3, DIVU = 3'd4,
                           MTHI = 3'd5, MTLO = 3'd6, MADD = 3'd7;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cmp_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mul_div_unit_if #(.WIDTH(32)) bus0 ();
    mul_div_unit_if #(.WIDTH(16)) bus1 ();

    mul_div_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) u0 (
        .clk(clk), .reset(reset), .md(bus0)
    );
    mul_div_unit #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(3)) u1 (
        .clk(clk), .reset(reset), .md(bus1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result of a multi-cycle op, {write_enable, HI, LO}, from plain arithmetic.
    function automatic logic [64:0] model_op(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hi,
                                             input logic [31:0] lo);
        logic [63:0] r;
        longint      sp;
        int          q, rm;
        r = '0;
        case (op)
            MULT: begin
                sp = longint'(int'(a)) * longint'(int'(b));
                r  = sp;
            end
            MULTU: r = {32'b0, a} * {32'b0, b};
            MADD: begin
                sp = longint'({hi, lo}) + longint'(int'(a)) * longint'(int'(b));
                r  = sp;
            end
            DIV: begin
                if (b == 32'd0) return {1'b0, 64'd0};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r = {32'h0, 32'h8000_0000};
                end else begin
                    q  = int'(a) / int'(b);
                    rm = int'(a) % int'(b);
                    r  = {32'(rm), 32'(q)};
                end
            end
            DIVU: begin
                if (b == 32'd0) return {1'b0, 64'd0};
                r = {a % b, a / b};
            end
            default: return {1'b0, 64'd0};
        endcase
        return {1'b1, r};
    endfunction

    // Reference model of the 32-bit unit, tracked per clock edge by edge count.
    logic [31:0] m_hi, m_lo;
    logic        m_busy;
    logic [64:0] m_pend;
    int          cyc, done_at;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi <= '0; m_lo <= '0; m_busy <= 1'b0; m_pend <= '0; cyc <= 0; done_at <= 0;
        end else begin
            cyc <= cyc + 1;
            if (m_busy) begin
                if (cyc == done_at) begin
                    m_busy <= 1'b0;
                    if (m_pend[64]) {m_hi, m_lo} <= m_pend[63:0];
                end
            end else if (bus0.start) begin
                case (bus0.md_op)
                    MULT, MULTU, MADD, DIV, DIVU: begin
                        m_pend  <= model_op(bus0.md_op, bus0.src_a, bus0.src_b, m_hi, m_lo);
                        m_busy  <= 1'b1;
                        done_at <= cyc + (((bus0.md_op == DIV) || (bus0.md_op == DIVU)) ? 10 : 5);
                    end
                    MTHI: m_hi <= bus0.src_a;
                    MTLO: m_lo <= bus0.src_a;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_busy", 64'(bus0.busy), 64'(m_busy));
            chk("cmp_hi", 64'(bus0.hi), 64'(m_hi));
            chk("cmp_lo", 64'(bus0.lo), 64'(m_lo));
        end
    end

    // Called at negedge+2; drives one start pulse across the next rising edge.
    task automatic issue(input bit which, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (which == 1'b0) begin
            bus0.start = 1'b1; bus0.md_op = op; bus0.src_a = a; bus0.src_b = b;
        end else begin
            bus1.start = 1'b1; bus1.md_op = op; bus1.src_a = a[15:0]; bus1.src_b = b[15:0];
        end
        @(negedge clk); #2;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
    endtask

    // Counts sampled cycles with busy high, starting from the current sample.
    task automatic wait_idle(input bit which, output int n);
        n = 0;
        while (((which == 1'b0) ? bus0.busy : bus1.busy) && n < 50) begin
            n++;
            @(negedge clk); #2;
        end
        if (n >= 50) chk("busy_timeout", 64'(n), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus0.start = 1'b0; bus0.md_op = NOP; bus0.src_a = '0; bus0.src_b = '0;
        bus1.start = 1'b0; bus1.md_op = NOP; bus1.src_a = '0; bus1.src_b = '0;

        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(bus0.busy), 64'd0);
        chk("rst_hi", 64'(bus0.hi), 64'd0);
        chk("rst_lo", 64'(bus0.lo), 64'd0);
        #2 reset = 1'b0;
        cmp_en = 1'b1;

        issue(0, MULT, 32'hFFFF_FFFD, 32'd5);
        wait_idle(0, n);
        chk("mult_cycles", 64'(n), 64'd5);
        chk("mult_hi", 64'(bus0.hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(bus0.lo), 64'hFFFF_FFF1);

        issue(0, DIVU, 32'd100, 32'd7);
        wait_idle(0, n);
        chk("divu_cycles", 64'(n), 64'd10);
        chk("divu_lo", 64'(bus0.lo), 64'h0000_000E);
        chk("divu_hi", 64'(bus0.hi), 64'h0000_0002);

        issue(0, DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(0, n);
        chk("div_neg_lo", 64'(bus0.lo), 64'hFFFF_FFFD);
        chk("div_neg_hi", 64'(bus0.hi), 64'hFFFF_FFFF);

        issue(0, DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(0, n);
        chk("div_ovf_lo", 64'(bus0.lo), 64'h8000_0000);
        chk("div_ovf_hi", 64'(bus0.hi), 64'h0);

        // MTHI then MTLO on consecutive edges; each visible right after its edge.
        issue(0, MTHI, 32'h1234_5678, 32'd0);
        chk("mthi_hi", 64'(bus0.hi), 64'h1234_5678);
        issue(0, MTLO, 32'h9ABC_DEF0, 32'd0);
        chk("mtlo_lo", 64'(bus0.lo), 64'h9ABC_DEF0);
        chk("mt_busy", 64'(bus0.busy), 64'd0);
        issue(0, DIV, 32'd5, 32'd0);
        wait_idle(0, n);
        chk("div0_cycles", 64'(n), 64'd10);
        chk("div0_hi", 64'(bus0.hi), 64'h1234_5678);
        chk("div0_lo", 64'(bus0.lo), 64'h9ABC_DEF0);

        issue(0, MTHI, 32'd0, 32'd0);
        issue(0, MTLO, 32'hFFFF_FFFF, 32'd0);
        issue(0, MADD, 32'd1, 32'd1);
        wait_idle(0, n);
        chk("madd_hi", 64'(bus0.hi), 64'h0000_0001);
        chk("madd_lo", 64'(bus0.lo), 64'h0000_0000);

        issue(0, MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(0, MTLO, 32'h0000_AAAA, 32'd0);   // lands in busy cycle 2, must be dropped
        chk("ign_lo_during", 64'(bus0.lo), 64'h0000_0000);
        wait_idle(0, n);
        chk("multu_cycles", 64'(n + 1), 64'd5);
        chk("multu_hi", 64'(bus0.hi), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(bus0.lo), 64'h0000_0001);

        issue(0, DIVU, 32'd1000, 32'd3);
        repeat (3) begin @(negedge clk); #2; end
        chk("pre_rst_busy", 64'(bus0.busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("abort_busy", 64'(bus0.busy), 64'd0);
        chk("abort_hi", 64'(bus0.hi), 64'd0);
        chk("abort_lo", 64'(bus0.lo), 64'd0);
        @(negedge clk); #2;
        reset = 1'b0;
        issue(0, MULT, 32'd2, 32'd3);
        wait_idle(0, n);
        chk("post_rst_cycles", 64'(n), 64'd5);
        chk("post_rst_lo", 64'(bus0.lo), 64'd6);
        chk("post_rst_hi", 64'(bus0.hi), 64'd0);

        issue(1, MULT, 32'h8000, 32'h8000);
        wait_idle(1, n);
        chk("w16_mult_cycles", 64'(n), 64'd1);
        chk("w16_mult_hi", 64'(bus1.hi), 64'h4000);
        chk("w16_mult_lo", 64'(bus1.lo), 64'h0000);

        issue(1, DIV, 32'hFFF9, 32'd2);
        wait_idle(1, n);
        chk("w16_div_cycles", 64'(n), 64'd3);
        chk("w16_div_lo", 64'(bus1.lo), 64'hFFFD);
        chk("w16_div_hi", 64'(bus1.hi), 64'hFFFF);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
